// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined
//   Instruction decode stage with the ID/EX pipeline register. Splits the
//   instruction into fields and reads the register file. The register file has
//   write-through, so data written back this cycle is seen at once. The stage
//   decodes EX/MEM/WB controls and detects load-use hazards. A hazard raises
//   o_stall so that IF holds. A bubble goes into ID/EX on a stall, a flush or
//   an invalid input.
//
//   Ports
//     i_clock, i_reset          rising-edge clock, asynchronous active-high reset
//     i_valid, i_instruction,   instruction (and its PC+4) from IF/ID
//     i_pc
//     i_flush                   kill the instruction in ID (taken branch)
//     i_wb_wr_enb/addr/data     register file write port from WB
//     o_stall                   combinational hold request to IF
//     o_valid ... o_mem_to_reg  registered ID/EX contents
//
//   Optional feature: define STALL_COUNTER_EN to add the saturating
//   o_stall_count / o_flush_count performance counters.
module decode_stage_pipelined #(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = 5,
  parameter int NB_PC     = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_CNT    = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_DATA-1:0]   i_instruction,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic                 i_flush,
  input  logic                 i_wb_wr_enb,
  input  logic [NB_ADDR-1:0]   i_wb_wr_addr,
  input  logic [NB_DATA-1:0]   i_wb_data,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic [NB_DATA-1:0]   o_rs_data,
  output logic [NB_DATA-1:0]   o_rt_data,
  output logic [NB_DATA-1:0]   o_imm,
  output logic [NB_ADDR-1:0]   o_sa,
  output logic [NB_PC-1:0]     o_pc,
  output logic [NB_ADDR-1:0]   o_rs_addr,
  output logic [NB_ADDR-1:0]   o_rt_addr,
  output logic [NB_ADDR-1:0]   o_wr_addr,
  output logic [NB_OPCODE-1:0] o_alu_opcode,
  output logic                 o_alu_src_imm,
  output logic                 o_mem_rd_enb,
  output logic                 o_mem_wr_enb,
  output logic                 o_branch,
  output logic                 o_branch_ne,
  output logic                 o_rf_wr_enb,
  output logic                 o_mem_to_reg
`ifdef STALL_COUNTER_EN
  ,
  output logic [NB_CNT-1:0]    o_stall_count,
  output logic [NB_CNT-1:0]    o_flush_count
`endif
);

  localparam int N_REGS = 2**NB_ADDR;
  localparam int NB_IMM = NB_DATA/2;

  localparam logic [NB_OPCODE-1:0] OP_RTYPE = '0;
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'(35);
  localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'(43);

  typedef struct packed {
    logic                 valid;
    logic [NB_DATA-1:0]   rs_data;
    logic [NB_DATA-1:0]   rt_data;
    logic [NB_DATA-1:0]   imm;
    logic [NB_ADDR-1:0]   sa;
    logic [NB_PC-1:0]     pc;
    logic [NB_ADDR-1:0]   rs_addr;
    logic [NB_ADDR-1:0]   rt_addr;
    logic [NB_ADDR-1:0]   wr_addr;
    logic [NB_OPCODE-1:0] alu_opcode;
    logic                 alu_src_imm;
    logic                 mem_rd_enb;
    logic                 mem_wr_enb;
    logic                 branch;
    logic                 branch_ne;
    logic                 rf_wr_enb;
    logic                 mem_to_reg;
  } idex_t;

  // ANDI/ORI/XORI/LUI (0011xx) zero-extend; every other immediate sign-extends.
  function automatic logic [NB_DATA-1:0] extend_imm(input logic [NB_OPCODE-1:0] op,
                                                    input logic [NB_IMM-1:0] imm);
    if ((op >> 2) == NB_OPCODE'(3)) return {{(NB_DATA-NB_IMM){1'b0}}, imm};
    return {{(NB_DATA-NB_IMM){imm[NB_IMM-1]}}, imm};
  endfunction

  logic [NB_OPCODE-1:0] op, funct;
  logic [NB_ADDR-1:0]   rs, rt, rd, sa;
  logic [NB_IMM-1:0]    imm;

  assign op    = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign rs    = i_instruction[NB_DATA-NB_OPCODE-1 -: NB_ADDR];
  assign rt    = i_instruction[NB_DATA-NB_OPCODE-NB_ADDR-1 -: NB_ADDR];
  assign rd    = i_instruction[NB_DATA-NB_OPCODE-2*NB_ADDR-1 -: NB_ADDR];
  assign sa    = i_instruction[NB_DATA-NB_OPCODE-3*NB_ADDR-1 -: NB_ADDR];
  assign funct = i_instruction[NB_OPCODE-1:0];
  assign imm   = i_instruction[NB_IMM-1:0];

  logic [NB_DATA-1:0] regs [N_REGS];
  logic [NB_DATA-1:0] rs_rd, rt_rd;
  logic               reads_rt, hazard, bubble;
  idex_t              idex_p0, idex_p1;

  // Write-through read: a register being written this cycle returns the new data.
  assign rs_rd = (rs == '0) ? '0 :
                 (i_wb_wr_enb && i_wb_wr_addr == rs) ? i_wb_data : regs[rs];
  assign rt_rd = (rt == '0) ? '0 :
                 (i_wb_wr_enb && i_wb_wr_addr == rt) ? i_wb_data : regs[rt];

  // Load-use hazard against the load now sitting in ID/EX. Only R-type, SW and
  // branches read rt as a source; ALU-imm and LW use rt as their destination.
  assign reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign hazard   = idex_p1.valid && idex_p1.mem_rd_enb && (idex_p1.wr_addr != '0) && i_valid &&
                    ((idex_p1.wr_addr == rs) || ((idex_p1.wr_addr == rt) && reads_rt));
  // A flush kills the dependent instruction, so there is nothing to hold.
  assign o_stall  = hazard && !i_flush;
  assign bubble   = i_flush || hazard || !i_valid;

  always_comb begin
    idex_p0            = '0;
    idex_p0.rs_data    = rs_rd;
    idex_p0.rt_data    = rt_rd;
    idex_p0.imm        = extend_imm(op, imm);
    idex_p0.sa         = sa;
    idex_p0.pc         = i_pc;
    idex_p0.rs_addr    = rs;
    idex_p0.rt_addr    = rt;
    idex_p0.wr_addr    = rt;
    idex_p0.alu_opcode = op;
    if (op == OP_RTYPE) begin
      idex_p0.wr_addr    = rd;
      idex_p0.alu_opcode = funct;
      idex_p0.rf_wr_enb  = 1'b1;
    end else if ((op >> 3) == NB_OPCODE'(1)) begin
      idex_p0.rf_wr_enb   = 1'b1;
      idex_p0.alu_src_imm = 1'b1;
    end else if (op == OP_LW) begin
      idex_p0.mem_rd_enb  = 1'b1;
      idex_p0.rf_wr_enb   = 1'b1;
      idex_p0.mem_to_reg  = 1'b1;
      idex_p0.alu_src_imm = 1'b1;
    end else if (op == OP_SW) begin
      idex_p0.mem_wr_enb  = 1'b1;
      idex_p0.alu_src_imm = 1'b1;
    end else if (op == OP_BEQ) begin
      idex_p0.branch = 1'b1;
    end else if (op == OP_BNE) begin
      idex_p0.branch_ne = 1'b1;
    end
    idex_p0.valid = 1'b1;
    if (bubble) begin
      idex_p0.valid       = 1'b0;
      idex_p0.alu_src_imm = 1'b0;
      idex_p0.mem_rd_enb  = 1'b0;
      idex_p0.mem_wr_enb  = 1'b0;
      idex_p0.branch      = 1'b0;
      idex_p0.branch_ne   = 1'b0;
      idex_p0.rf_wr_enb   = 1'b0;
      idex_p0.mem_to_reg  = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (i_wb_wr_enb && i_wb_wr_addr != '0) begin
      regs[i_wb_wr_addr] <= i_wb_data;
    end
  end

  // ---- ID / EX boundary ----
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) idex_p1 <= '0;
    else         idex_p1 <= idex_p0;
  end

  assign o_valid       = idex_p1.valid;
  assign o_rs_data     = idex_p1.rs_data;
  assign o_rt_data     = idex_p1.rt_data;
  assign o_imm         = idex_p1.imm;
  assign o_sa          = idex_p1.sa;
  assign o_pc          = idex_p1.pc;
  assign o_rs_addr     = idex_p1.rs_addr;
  assign o_rt_addr     = idex_p1.rt_addr;
  assign o_wr_addr     = idex_p1.wr_addr;
  assign o_alu_opcode  = idex_p1.alu_opcode;
  assign o_alu_src_imm = idex_p1.alu_src_imm;
  assign o_mem_rd_enb  = idex_p1.mem_rd_enb;
  assign o_mem_wr_enb  = idex_p1.mem_wr_enb;
  assign o_branch      = idex_p1.branch;
  assign o_branch_ne   = idex_p1.branch_ne;
  assign o_rf_wr_enb   = idex_p1.rf_wr_enb;
  assign o_mem_to_reg  = idex_p1.mem_to_reg;

`ifdef STALL_COUNTER_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_stall_count <= '0;
      o_flush_count <= '0;
    end else begin
      if (o_stall && o_stall_count != '1)                 o_stall_count <= o_stall_count + 1'b1;
      if (i_flush && i_valid && o_flush_count != '1)      o_flush_count <= o_flush_count + 1'b1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^NB_CNT;
`endif

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the decode stage.
module tb_decode_stage_pipelined;
  localparam int NB_CNT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_flush, i_wb_wr_enb;
  logic [31:0] i_instruction, i_pc, i_wb_data;
  logic [4:0]  i_wb_wr_addr;
  logic        o_stall, o_valid, o_alu_src_imm, o_mem_rd_enb, o_mem_wr_enb;
  logic        o_branch, o_branch_ne, o_rf_wr_enb, o_mem_to_reg;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc;
  logic [4:0]  o_sa, o_rs_addr, o_rt_addr, o_wr_addr;
  logic [5:0]  o_alu_opcode;
`ifdef STALL_COUNTER_EN
  logic [NB_CNT-1:0] o_stall_count, o_flush_count;
`endif

  always #5 clk = ~clk;

  decode_stage_pipelined #(.NB_CNT(NB_CNT)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc(i_pc), .i_flush(i_flush), .i_wb_wr_enb(i_wb_wr_enb),
    .i_wb_wr_addr(i_wb_wr_addr), .i_wb_data(i_wb_data), .o_stall(o_stall),
    .o_valid(o_valid), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_sa(o_sa), .o_pc(o_pc), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_wr_addr(o_wr_addr), .o_alu_opcode(o_alu_opcode), .o_alu_src_imm(o_alu_src_imm),
    .o_mem_rd_enb(o_mem_rd_enb), .o_mem_wr_enb(o_mem_wr_enb), .o_branch(o_branch),
    .o_branch_ne(o_branch_ne), .o_rf_wr_enb(o_rf_wr_enb), .o_mem_to_reg(o_mem_to_reg)
`ifdef STALL_COUNTER_EN
    , .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: register file contents and the expected ID/EX contents.
  logic [31:0] mregs [32];
  logic        e_valid, e_src, e_mrd, e_mwr, e_br, e_bne, e_wr, e_m2r;
  logic [31:0] e_rs_data, e_rt_data, e_imm, e_pc;
  logic [4:0]  e_sa, e_rs_addr, e_rt_addr, e_wr_addr;
  logic [5:0]  e_alu;
  int          e_scnt, e_fcnt;
  logic        last_exp_stall, last_obs_stall;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    {e_valid, e_src, e_mrd, e_mwr, e_br, e_bne, e_wr, e_m2r} = '0;
    {e_rs_data, e_rt_data, e_imm, e_pc} = '0;
    {e_sa, e_rs_addr, e_rt_addr, e_wr_addr} = '0;
    e_alu = '0; e_scnt = 0; e_fcnt = 0;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    rtype = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    itype = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check_outputs();
    chk("valid", o_valid, e_valid);
    chk("mem_rd", o_mem_rd_enb, e_mrd);
    chk("mem_wr", o_mem_wr_enb, e_mwr);
    chk("branch", o_branch, e_br);
    chk("branch_ne", o_branch_ne, e_bne);
    chk("rf_wr", o_rf_wr_enb, e_wr);
    if (e_valid) begin
      chk("rs_data", o_rs_data, e_rs_data);
      chk("rt_data", o_rt_data, e_rt_data);
      chk("imm", o_imm, e_imm);
      chk("sa", o_sa, e_sa);
      chk("pc", o_pc, e_pc);
      chk("rs_addr", o_rs_addr, e_rs_addr);
      chk("rt_addr", o_rt_addr, e_rt_addr);
      chk("wr_addr", o_wr_addr, e_wr_addr);
      chk("alu_op", o_alu_opcode, e_alu);
      chk("alu_src", o_alu_src_imm, e_src);
      chk("mem_to_reg", o_mem_to_reg, e_m2r);
    end
`ifdef STALL_COUNTER_EN
    chk("stall_count", o_stall_count, e_scnt);
    chk("flush_count", o_flush_count, e_fcnt);
`endif
  endtask

  // One clock of traffic: drive at negedge, check the combinational stall,
  // predict the ID/EX contents, then check them just after the rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input int wa, input logic [31:0] wd);
    int op, rs, rt, rd;
    logic reads_rt, hz, exp_stall;
    @(negedge clk);
    i_valid = v; i_instruction = ins; i_flush = fl; i_pc = $urandom;
    i_wb_wr_enb = we; i_wb_wr_addr = 5'(wa); i_wb_data = wd;
    #1;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    reads_rt  = (op == 0) || (op == 43) || (op == 4) || (op == 5);
    hz        = e_valid && e_mrd && (e_wr_addr != 0) && v &&
                ((int'(e_wr_addr) == rs) || ((int'(e_wr_addr) == rt) && reads_rt));
    exp_stall = hz && !fl;
    chk("stall", o_stall, exp_stall);
    last_exp_stall = exp_stall;
    last_obs_stall = o_stall;
    if (exp_stall && e_scnt < (2**NB_CNT - 1)) e_scnt++;
    if (fl && v && e_fcnt < (2**NB_CNT - 1)) e_fcnt++;
    if (fl || hz || !v) begin
      {e_valid, e_src, e_mrd, e_mwr, e_br, e_bne, e_wr, e_m2r} = '0;
    end else begin
      e_valid   = 1'b1;
      e_rs_addr = 5'(rs); e_rt_addr = 5'(rt); e_sa = ins[10:6]; e_pc = i_pc;
      e_rs_data = (rs == 0) ? 32'h0 : (we && wa == rs) ? wd : mregs[rs];
      e_rt_data = (rt == 0) ? 32'h0 : (we && wa == rt) ? wd : mregs[rt];
      e_imm     = (op >= 12 && op <= 15) ? {16'h0, ins[15:0]} : 32'($signed(ins[15:0]));
      e_alu     = (op == 0) ? ins[5:0] : 6'(op);
      e_wr_addr = (op == 0) ? 5'(rd) : 5'(rt);
      e_wr  = (op == 0) || (op >= 8 && op <= 15) || (op == 35);
      e_src = (op >= 8 && op <= 15) || (op == 35) || (op == 43);
      e_mrd = (op == 35); e_m2r = (op == 35); e_mwr = (op == 43);
      e_br  = (op == 4);  e_bne = (op == 5);
    end
    @(posedge clk);
    if (we && wa != 0) mregs[wa] = wd;
    #1;
    check_outputs();
  endtask

  int op_pool [12] = '{0, 8, 9, 10, 12, 13, 14, 15, 35, 43, 4, 5};

  initial begin
    logic        cur_v, hold;
    logic [31:0] cur_ins;
    rst = 1'b1; i_valid = 0; i_instruction = 0; i_pc = 0; i_flush = 0;
    i_wb_wr_enb = 0; i_wb_wr_addr = 0; i_wb_data = 0;
    model_reset();
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_rf_wr", o_rf_wr_enb, 0);
    chk("rst_pc", o_pc, 0);
    @(negedge clk); rst = 1'b0;

    // Preload r1, r3.
    step(0, 32'h0, 0, 1, 1, 32'h100);
    step(0, 32'h0, 0, 1, 3, 32'h30);

    // Write-through of r5 into ADD r3,r5,r5; write to r0 is ignored.
    step(1, rtype(5, 5, 3, 32), 0, 1, 5, 32'h1234);
    chk("t2_rs", o_rs_data, 32'h1234);
    chk("t2_rt", o_rt_data, 32'h1234);
    step(0, 32'h0, 0, 1, 0, 32'hDEAD);
    step(1, rtype(0, 0, 3, 32), 0, 0, 0, 0);
    chk("t2_r0", o_rs_data, 32'h0);

    // LW r2,4(r1) then ADD r4,r2,r3: one stall, one bubble, then ADD.
    step(1, itype(35, 1, 2, 4), 0, 0, 0, 0);
    step(1, rtype(2, 3, 4, 32), 0, 0, 0, 0);
    chk("t3_stall", last_obs_stall, 1);
    chk("t3_bubble", o_valid, 0);
    step(1, rtype(2, 3, 4, 32), 0, 0, 0, 0);
    chk("t3_nostall", last_obs_stall, 0);
    chk("t3_issue", o_valid, 1);

    // ADDI sign-extends, ORI zero-extends.
    step(1, itype(35, 1, 2, 4), 0, 0, 0, 0);
    step(1, itype(8, 2, 7, 16'hFFFF), 0, 0, 0, 0);
    chk("t4_addi_stall", last_obs_stall, 1);
    step(1, itype(8, 2, 7, 16'hFFFF), 0, 0, 0, 0);
    chk("t4_addi_imm", o_imm, 32'hFFFFFFFF);
    step(1, itype(35, 1, 2, 4), 0, 0, 0, 0);
    step(1, itype(13, 2, 7, 16'hFFFF), 0, 0, 0, 0);
    chk("t4_ori_stall", last_obs_stall, 1);
    step(1, itype(13, 2, 7, 16'hFFFF), 0, 0, 0, 0);
    chk("t4_ori_imm", o_imm, 32'h0000FFFF);

    // Flush over a pending hazard, then an invalid slot.
    step(1, itype(35, 1, 2, 4), 0, 0, 0, 0);
    step(1, rtype(2, 3, 4, 32), 1, 0, 0, 0);
    chk("t5_flush_stall", last_obs_stall, 0);
    chk("t5_flush_bubble", o_valid, 0);
    step(0, rtype(1, 3, 4, 32), 0, 0, 0, 0);
    chk("t5_invalid_bubble", o_valid, 0);

    // Reset asserted in the middle of a stall.
    step(1, itype(35, 1, 2, 4), 0, 0, 0, 0);
    @(negedge clk);
    i_valid = 1; i_instruction = rtype(2, 3, 4, 32); i_flush = 0; i_wb_wr_enb = 0;
    #1;
    chk("t1_stall_pre", o_stall, 1);
    rst = 1'b1;
    #1;
    chk("t1_stall_rst", o_stall, 0);
    chk("t1_valid_rst", o_valid, 0);
    chk("t1_mem_rd_rst", o_mem_rd_enb, 0);
    chk("t1_rs_data_rst", o_rs_data, 0);
    @(posedge clk); #1;
    chk("t1_valid_hold", o_valid, 0);
    @(negedge clk); rst = 1'b0; i_valid = 0;
    model_reset();
    step(1, rtype(5, 1, 3, 32), 0, 0, 0, 0);
    chk("t1_rf_clear", o_rs_data, 32'h0);

    // Randomized traffic; IF holds its instruction while stalled.
    hold = 0; cur_v = 0; cur_ins = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [5:0] op;
      if (!hold) begin
        op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'(op_pool[$urandom_range(0, 11)]);
        cur_v   = ($urandom_range(0, 9) != 0);
        cur_ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
      end
      step(cur_v, cur_ins, ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom);
      hold = last_exp_stall;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
